// File: rtl/rca_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
// The slave side is the arithmetic unit; the master side is the
// operand source together with the result consumer.
interface rca_pipe_addsub_if #(
  parameter int WIDTH = 40
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry add/subtract unit.
// The WIDTH-bit carry chain is cut into SEG_W-bit segments with one register
// stage per segment. Each stage adds its own segment, forwards the carry,
// keeps the operand bits that later stages still need (skew registers) and
// accumulates the sum segments finished so far. A single global advance
// signal moves the whole pipe, so a stalled output freezes every stage.
module rca_pipe_addsub #(
  parameter int WIDTH = 40,
  parameter int SEG_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  rca_pipe_addsub_if.slave  bus
);
  localparam int STAGES = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0) begin : g_cfg_err
    $error("rca_pipe_addsub: WIDTH must be a multiple of SEG_W");
  end

  // Whole pipe moves when the output slot is empty or being drained.
  logic adv_s;
  logic out_valid_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits not yet consumed, including this stage's segment.
    // DONE: sum bits complete once this stage has registered.
    localparam int REM  = WIDTH - k * SEG_W;
    localparam int DONE = (k + 1) * SEG_W;

    logic [REM-1:0]   a_s;
    logic [REM-1:0]   b_s;
    logic             c_s;
    logic             v_s;
    logic [SEG_W:0]   seg_s;
    logic [DONE-1:0]  sum_next_s;
    logic             v_r;
    logic             c_r;
    logic [DONE-1:0]  sum_r;

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + ~Cin, so the raw carry out means "no borrow".
      assign a_s = bus.A;
      assign b_s = bus.sub ? ~bus.B : bus.B;
      assign c_s = bus.sub ? ~bus.Cin : bus.Cin;
      assign v_s = bus.in_valid & adv_s;
    end else begin : g_src
      assign a_s = g_stage[k-1].g_skew.a_skew_r;
      assign b_s = g_stage[k-1].g_skew.b_skew_r;
      assign c_s = g_stage[k-1].c_r;
      assign v_s = g_stage[k-1].v_r;
    end

    assign seg_s = {1'b0, a_s[SEG_W-1:0]} + {1'b0, b_s[SEG_W-1:0]}
                 + {{SEG_W{1'b0}}, c_s};

    if (k == 0) begin : g_sum
      assign sum_next_s = seg_s[SEG_W-1:0];
    end else begin : g_sum
      assign sum_next_s = {seg_s[SEG_W-1:0], g_stage[k-1].sum_r};
    end

    // Beat valid, segment carry and partial sum travel together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= {DONE{1'b0}};
      end else if (adv_s) begin
        v_r   <= v_s;
        c_r   <= seg_s[SEG_W];
        sum_r <= sum_next_s;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [REM-SEG_W-1:0] a_skew_r;
      logic [REM-SEG_W-1:0] b_skew_r;

      // Carry the not-yet-added operand segments forward to later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_skew_r <= {(REM-SEG_W){1'b0}};
          b_skew_r <= {(REM-SEG_W){1'b0}};
        end else if (adv_s) begin
          a_skew_r <= a_s[REM-1:SEG_W];
          b_skew_r <= b_s[REM-1:SEG_W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      logic cmsb_s;
      logic ovf_r;

      assign cmsb_s = seg_s[SEG_W-1] ^ a_s[SEG_W-1] ^ b_s[SEG_W-1];

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv_s) begin
          ovf_r <= cmsb_s ^ seg_s[SEG_W];
        end
      end
    end
  end

  assign out_valid_s   = g_stage[STAGES-1].v_r;
  assign adv_s         = ~out_valid_s | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_s;
  assign bus.S         = g_stage[STAGES-1].sum_r;
  assign bus.Cout      = g_stage[STAGES-1].c_r;
  assign bus.Ovf       = g_stage[STAGES-1].g_last.ovf_r;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub: a 40/8 five-stage instance and a
// 16/16 single-stage instance, checked against an arithmetic reference model.
module tb_rca_pipe_addsub;
  logic clk;
  logic rst_n;

  rca_pipe_addsub_if #(.WIDTH(40)) bus ();
  rca_pipe_addsub_if #(.WIDTH(16)) bus16 ();

  rca_pipe_addsub #(.WIDTH(40), .SEG_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rca_pipe_addsub #(.WIDTH(16), .SEG_W(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   stalled_q = 1'b0;
  bit   seen_valid = 1'b0;
  bit   last_acc = 1'b0;

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic is_sub);
    res_t o;
    longint unsigned span, ua, ub, full;
    longint sa, sbv, r, lim;
    span = 64'd1 << w;
    ua = a & (span - 64'd1);
    ub = b & (span - 64'd1);
    sa  = (ua >= span / 2) ? longint'(ua) - longint'(span) : longint'(ua);
    sbv = (ub >= span / 2) ? longint'(ub) - longint'(span) : longint'(ub);
    if (!is_sub) begin
      full   = ua + ub + 64'(cin);
      o.s    = full & (span - 64'd1);
      o.cout = (full >= span);
      r      = sa + sbv + longint'(cin);
    end else begin
      o.s    = (ua - ub - 64'(cin)) & (span - 64'd1);
      o.cout = (ua >= ub + 64'(cin));
      r      = sa - sbv - longint'(cin);
    end
    lim   = longint'(span / 2);
    o.ovf = (r >= lim) || (r < -lim);
    return o;
  endfunction

  function automatic logic [39:0] rand_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       r = 64'h0;
      1:       r = 64'hFF_FFFF_FFFF;
      2:       r = 64'h7F_FFFF_FFFF;
      3:       r = 64'h80_0000_0000;
      default: r = r;
    endcase
    return r[39:0];
  endfunction

  // One clock of the 40-bit instance: drive at negedge, sample 1 ns later.
  task automatic step(input logic iv, input logic [39:0] a, input logic [39:0] b,
                      input logic cin, input logic is_sub, input logic ordy);
    res_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.Cin       = cin;
    bus.sub       = is_sub;
    bus.out_ready = ordy;
    #1;
    seen_valid = bus.out_valid;
    check_val("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !ordy)));
    if (stalled_q) check_val("stall_hold_valid", 64'(bus.out_valid), 64'd1);
    if (bus.out_valid) begin
      check_val("valid_without_beat", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check_val("S", 64'(bus.S), e.s);
        check_val("Cout", 64'(bus.Cout), 64'(e.cout));
        check_val("Ovf", 64'(bus.Ovf), 64'(e.ovf));
        if (ordy) void'(exp_q.pop_front());
      end
    end
    stalled_q = bus.out_valid && !ordy;
    last_acc  = iv && bus.in_ready;
    if (last_acc) exp_q.push_back(model(40, {24'h0, a}, {24'h0, b}, cin, is_sub));
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 40'h0, 40'h0, 1'b0, 1'b0, ordy);
  endtask

  // Single beat into an empty pipe, then measure cycles until out_valid.
  task automatic probe(input logic [39:0] a, input logic [39:0] b, input logic cin, input logic is_sub);
    int lat;
    lat = 0;
    step(1'b1, a, b, cin, is_sub, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      idle_step(1'b1);
      if (seen_valid) begin
        lat = i;
        break;
      end
    end
    check_val("latency", 64'(lat), 64'd5);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) idle_step(1'b1);
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit pat[4];
    res_t e;
    int sent, guard;
    logic [15:0] a16, b16;
    logic c16, s16;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = 40'h0; bus.B = 40'h0; bus.Cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.A = 16'h0; bus16.B = 16'h0; bus16.Cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b1;
    #3;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_S", 64'(bus.S), 64'd0);
    check_val("rst_Cout", 64'(bus.Cout), 64'd0);
    check_val("rst_Ovf", 64'(bus.Ovf), 64'd0);
    check_val("rst16_out_valid", 64'(bus16.out_valid), 64'd0);
    #19 rst_n = 1'b1;
    #1 check_val("in_ready_first", 64'(bus.in_ready), 64'd1);

    // Directed vectors, each also checking the 5-cycle latency.
    probe(40'h1, 40'h1, 1'b0, 1'b0);
    probe(40'h2, 40'h3, 1'b1, 1'b0);
    probe(40'h1, 40'hFF_FFFF_FFFF, 1'b0, 1'b0);
    probe(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
    probe(40'h0, 40'hFF_FFFF_FFFF, 1'b0, 1'b0);
    probe(40'h5, 40'h3, 1'b0, 1'b1);
    probe(40'h0, 40'h1, 1'b0, 1'b1);
    probe(40'h7F_FFFF_FFFF, 40'h1, 1'b0, 1'b0);

    // Spot-check the model itself against known answers.
    e = model(40, 64'h7F_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    check_val("model_ovf_S", e.s, 64'h80_0000_0000);
    check_val("model_ovf_flag", 64'(e.ovf), 64'd1);

    // Eight back-to-back beats with out_ready pattern 1,0,0,1,...
    sent = 0;
    guard = 0;
    while (sent < 8 && guard < 60) begin
      step(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pat[guard % 4]);
      if (last_acc) sent++;
      guard++;
    end
    check_val("bp_beats_sent", 64'(sent), 64'd8);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle_step(pat[(guard + i) % 4]);
    check_val("bp_drained", 64'(exp_q.size()), 64'd0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    drain(80);

    // Reset with beats in flight and a result already at the output.
    for (int i = 0; i < 6; i++) step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b1);
    check_val("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_S", 64'(bus.S), 64'd0);
    check_val("mid_rst_Cout", 64'(bus.Cout), 64'd0);
    exp_q.delete();
    stalled_q = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_val("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 12; i++) idle_step(1'b1);
    probe(40'h12_3456_789A, 40'h0F_0F0F_0F0F, 1'b1, 1'b1);

    // Single-stage 16-bit configuration: registered adder, latency 1.
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.A = 16'hFFFF; bus16.B = 16'h0001; bus16.Cin = 1'b0; bus16.sub = 1'b0;
    #1 check_val("w16_in_ready", 64'(bus16.in_ready), 64'd1);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    #1;
    check_val("w16_valid", 64'(bus16.out_valid), 64'd1);
    check_val("w16_S", 64'(bus16.S), 64'd0);
    check_val("w16_Cout", 64'(bus16.Cout), 64'd1);
    for (int i = 0; i < 20; i++) begin
      a16 = 16'($urandom());
      b16 = 16'($urandom());
      c16 = 1'($urandom_range(0, 1));
      s16 = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus16.in_valid = 1'b1; bus16.A = a16; bus16.B = b16; bus16.Cin = c16; bus16.sub = s16;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      #1;
      e = model(16, {48'h0, a16}, {48'h0, b16}, c16, s16);
      check_val("w16r_valid", 64'(bus16.out_valid), 64'd1);
      check_val("w16r_S", 64'(bus16.S), e.s);
      check_val("w16r_Cout", 64'(bus16.Cout), 64'(e.cout));
      check_val("w16r_Ovf", 64'(bus16.Ovf), 64'(e.ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
